// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared widths and source encodings for the writeback stage
// Purpose: register data width, register-cell count and source encodings used
//          by the writeback arbiter and its round-robin sub-arbiter.
// Ports:   none (package).
package writeback_arbiter_pkg;

   localparam int   LEN_REG = 16;
   localparam int   NUM_REG = 16;

   // Source encodings; also the bit positions in the two-bit request/grant vectors.
   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/writeback_arbiter_rr_arbiter2.sv
// rtl/writeback_arbiter_rr_arbiter2.sv - two-requester round-robin arbiter with priority state
// Purpose: grants one of two requesters per cycle; on contention the requester
//          named by prio wins, and after any grant prio moves to the other one.
// Ports:   clk, rst (sync, active low), req_i[1:0] (bit SRC_x = source x),
//          gnt_o[1:0] one-hot grant, forced to zero while rst is low.
module rr_arbiter2
   import writeback_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic prio_q;
   logic prio_d;

   always_comb begin
      gnt_o = 2'b00;
      if (rst) begin
         if (req_i == 2'b11) begin
            gnt_o = (prio_q == SRC_MEM) ? 2'b10 : 2'b01;
         end else begin
            gnt_o = req_i;
         end
      end
   end

   always_comb begin
      prio_d = prio_q;
      if (gnt_o[SRC_ALU]) begin
         prio_d = SRC_MEM;
      end else if (gnt_o[SRC_MEM]) begin
         prio_d = SRC_ALU;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         prio_q <= SRC_ALU;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - writeback stage arbitrating ALU and load results into the register cells
// Purpose: accepts one result per cycle from the ALU or the load unit (round
//          robin), checks the destination's write reservation and drives a
//          registered one-hot writeback select plus shared data bus.
// Ports:   clk, rst (sync, active low);
//          alu_valid_i/alu_ready_o/alu_dst_i/alu_data_i  ALU result handshake;
//          mem_valid_i/mem_ready_o/mem_dst_i/mem_data_i  load result handshake;
//          w_reserve_vec_i  per-register write reservations;
//          wb_o  one-hot writeback select; data_o  writeback data;
//          err_o  sticky: a result targeted an unreserved or out-of-range register.
// Option:  WB_FORWARD_EN adds fwd_valid_o, fwd_addr_o, fwd_data_o (bypass copy
//          of the writeback, valid in the same cycle as wb_o).
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int LEN_REG_P    = LEN_REG,
   parameter int NUM_REG_P    = NUM_REG,
   parameter int LEN_REG_ADDR = $clog2(NUM_REG_P)
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alu_valid_i,
   output logic                    alu_ready_o,
   input  logic [LEN_REG_ADDR-1:0] alu_dst_i,
   input  logic [LEN_REG_P-1:0]    alu_data_i,
   input  logic                    mem_valid_i,
   output logic                    mem_ready_o,
   input  logic [LEN_REG_ADDR-1:0] mem_dst_i,
   input  logic [LEN_REG_P-1:0]    mem_data_i,
   input  logic [NUM_REG_P-1:0]    w_reserve_vec_i,
   output logic [NUM_REG_P-1:0]    wb_o,
   output logic [LEN_REG_P-1:0]    data_o,
   output logic                    err_o
`ifdef WB_FORWARD_EN
   ,
   output logic                    fwd_valid_o,
   output logic [LEN_REG_ADDR-1:0] fwd_addr_o,
   output logic [LEN_REG_P-1:0]    fwd_data_o
`endif
);

   localparam logic [NUM_REG_P-1:0] WB_ONE = {{(NUM_REG_P-1){1'b0}}, 1'b1};

   logic [1:0]              gnt;
   logic                    hit;
   logic                    in_range;
   logic                    reserved;
   logic [LEN_REG_ADDR-1:0] sel_dst;
   logic [LEN_REG_P-1:0]    sel_data;

   logic [NUM_REG_P-1:0]    wb_q, wb_d;
   logic [LEN_REG_P-1:0]    data_q, data_d;
   logic                    err_q, err_d;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i ({mem_valid_i, alu_valid_i}),
      .gnt_o (gnt)
   );

   assign alu_ready_o = gnt[SRC_ALU];
   assign mem_ready_o = gnt[SRC_MEM];

   always_comb begin
      hit      = |gnt;
      sel_dst  = gnt[SRC_MEM] ? mem_dst_i  : alu_dst_i;
      sel_data = gnt[SRC_MEM] ? mem_data_i : alu_data_i;
      // Range check guards the reserve lookup when NUM_REG is not a power of two.
      in_range = (32'(sel_dst) < 32'(NUM_REG_P));
      reserved = in_range && w_reserve_vec_i[sel_dst];

      wb_d   = '0;
      data_d = data_q;
      err_d  = err_q;
      if (hit) begin
         if (reserved) begin
            wb_d   = WB_ONE << sel_dst;
            data_d = sel_data;
         end else begin
            // Result is still consumed so the source never stalls; it is dropped here.
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_q   <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wb_q   <= wb_d;
         data_q <= data_d;
         err_q  <= err_d;
      end
   end

   assign wb_o   = wb_q;
   assign data_o = data_q;
   assign err_o  = err_q;

`ifdef WB_FORWARD_EN
   logic                    fwd_valid_q, fwd_valid_d;
   logic [LEN_REG_ADDR-1:0] fwd_addr_q,  fwd_addr_d;

   always_comb begin
      fwd_valid_d = |wb_d;
      fwd_addr_d  = (hit && reserved) ? sel_dst : fwd_addr_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fwd_valid_q <= 1'b0;
         fwd_addr_q  <= '0;
      end else begin
         fwd_valid_q <= fwd_valid_d;
         fwd_addr_q  <= fwd_addr_d;
      end
   end

   assign fwd_valid_o = fwd_valid_q;
   assign fwd_addr_o  = fwd_addr_q;
   // Same register as data_o; it is loaded exactly when a forwarded writeback occurs.
   assign fwd_data_o  = data_q;
`endif

endmodule
